// File: rtl/attack_encoder.sv
// Per-player attack word generator: turns button presses and hitbox contact into
// the one-hot attack word, sequencing each move through startup/active/recovery.
module attack_encoder #(
    parameter int STARTUP_CYCLES  = 3,
    parameter int ACTIVE_CYCLES   = 4,
    parameter int RECOVERY_CYCLES = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        stun,
    input  logic        a_btn,
    input  logic        b_btn,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    input  logic        contact,
    output logic [31:0] attack,
    output logic        busy,
    output logic [1:0]  phase
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STARTUP  = 2'd1,
        ACTIVE   = 2'd2,
        RECOVERY = 2'd3
    } state_t;

    localparam int MAX_SA = (STARTUP_CYCLES > ACTIVE_CYCLES) ? STARTUP_CYCLES : ACTIVE_CYCLES;
    localparam int MAXC   = (MAX_SA > RECOVERY_CYCLES) ? MAX_SA : RECOVERY_CYCLES;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] ST_LAST = CW'(STARTUP_CYCLES - 1);
    localparam logic [CW-1:0] AC_LAST = CW'(ACTIVE_CYCLES - 1);
    localparam logic [CW-1:0] RC_LAST = CW'(RECOVERY_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] counter_reg, counter_next;
    // move one-hot maps directly onto attack[10:5]: A, up-B, down-B, left-B, right-B, neutral-B
    logic [5:0]    move_reg, move_next;
    logic [5:0]    buf_move_reg, buf_move_next;
    logic          buf_valid_reg, buf_valid_next;
    logic          hit_done_reg, hit_done_next;
    logic          a_prev_reg, b_prev_reg;
    logic [31:0]   attack_reg, attack_next;
    logic          busy_reg, busy_next;
    logic [1:0]    phase_reg, phase_next;

    logic          press_a, press_b, press_valid, last_cycle;
    logic [5:0]    press_move;

    assign press_a     = a_btn & ~a_prev_reg;
    assign press_b     = b_btn & ~b_prev_reg;
    assign press_valid = (press_a | press_b) & enable;

    always_comb begin
        press_move = 6'b000000;
        if (press_b) begin
            if (up)         press_move = 6'b000010;
            else if (down)  press_move = 6'b000100;
            else if (left)  press_move = 6'b001000;
            else if (right) press_move = 6'b010000;
            else            press_move = 6'b100000;
        end else if (press_a) begin
            press_move = 6'b000001;
        end
    end

    always_comb begin
        last_cycle = 1'b0;
        case (state_reg)
            STARTUP:  last_cycle = (counter_reg == ST_LAST);
            ACTIVE:   last_cycle = (counter_reg == AC_LAST);
            RECOVERY: last_cycle = (counter_reg == RC_LAST);
            default:  last_cycle = 1'b0;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        counter_next   = counter_reg;
        move_next      = move_reg;
        buf_move_next  = buf_move_reg;
        buf_valid_next = buf_valid_reg;
        hit_done_next  = hit_done_reg;
        attack_next    = 32'd0;
        busy_next      = (state_reg != IDLE);
        phase_next     = state_reg;

        if (state_reg == ACTIVE && !stun) begin
            attack_next[10:5] = move_reg;
            if (contact && !hit_done_reg) begin
                attack_next[0] = 1'b1;
                hit_done_next  = 1'b1;
            end
        end

        if (stun) begin
            state_next     = IDLE;
            counter_next   = '0;
            buf_valid_next = 1'b0;
            hit_done_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // a fresh press overrides whatever was buffered during recovery
                    if (press_valid || buf_valid_reg) begin
                        move_next      = press_valid ? press_move : buf_move_reg;
                        state_next     = STARTUP;
                        counter_next   = '0;
                        hit_done_next  = 1'b0;
                        buf_valid_next = 1'b0;
                    end
                end
                STARTUP, ACTIVE: begin
                    if (last_cycle) begin
                        state_next   = (state_reg == STARTUP) ? ACTIVE : RECOVERY;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_reg + CW'(1);
                    end
                end
                RECOVERY: begin
                    if (press_valid) begin
                        buf_valid_next = 1'b1;
                        buf_move_next  = press_move;
                    end
                    if (last_cycle) begin
                        state_next   = IDLE;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_reg + CW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            counter_reg   <= '0;
            move_reg      <= '0;
            buf_move_reg  <= '0;
            buf_valid_reg <= 1'b0;
            hit_done_reg  <= 1'b0;
            a_prev_reg    <= 1'b0;
            b_prev_reg    <= 1'b0;
            attack_reg    <= 32'd0;
            busy_reg      <= 1'b0;
            phase_reg     <= 2'd0;
        end else begin
            state_reg     <= state_next;
            counter_reg   <= counter_next;
            move_reg      <= move_next;
            buf_move_reg  <= buf_move_next;
            buf_valid_reg <= buf_valid_next;
            hit_done_reg  <= hit_done_next;
            a_prev_reg    <= a_btn;
            b_prev_reg    <= b_btn;
            attack_reg    <= attack_next;
            busy_reg      <= busy_next;
            phase_reg     <= phase_next;
        end
    end

    assign attack = attack_reg;
    assign busy   = busy_reg;
    assign phase  = phase_reg;

endmodule

// File: tb/tb_attack_encoder.sv
// Bench for attack_encoder: directed move scenarios with literal expectations plus
// randomized play compared every cycle against a frame-countdown model.
module tb_attack_encoder;

    localparam int ST = 3;
    localparam int AC = 4;
    localparam int RC = 6;

    logic        clock, reset, enable, stun, a_btn, b_btn, up, down, left, right, contact;
    logic [31:0] attack;
    logic        busy;
    logic [1:0]  phase;

    attack_encoder #(.STARTUP_CYCLES(ST), .ACTIVE_CYCLES(AC), .RECOVERY_CYCLES(RC)) dut (
        .clock(clock), .reset(reset), .enable(enable), .stun(stun),
        .a_btn(a_btn), .b_btn(b_btn), .up(up), .down(down), .left(left), .right(right),
        .contact(contact), .attack(attack), .busy(busy), .phase(phase)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    endtask

    // Behavioural model: phase number plus frames remaining in that phase.
    int          m_ph, m_left;
    logic [31:0] m_word, m_buf_word, nw;
    bit          m_hit, m_buf, m_ap, m_bp, pa, pb, press;
    logic [31:0] e_att;
    logic        e_busy;
    logic [1:0]  e_ph;

    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            m_ph = 0; m_left = 0; m_word = 0; m_buf_word = 0;
            m_hit = 0; m_buf = 0; m_ap = 0; m_bp = 0;
            e_att = 0; e_busy = 0; e_ph = 0;
        end else begin
            pa = a_btn && !m_ap;
            pb = b_btn && !m_bp;
            if (pb)      nw = up ? 32'h40 : down ? 32'h80 : left ? 32'h100 : right ? 32'h200 : 32'h400;
            else if (pa) nw = 32'h20;
            else         nw = 32'h0;
            press = (pa || pb) && enable;

            e_ph   = 2'(m_ph);
            e_busy = (m_ph != 0);
            e_att  = 0;
            if (m_ph == 2 && !stun) begin
                e_att = m_word;
                if (contact && !m_hit) begin
                    e_att = e_att | 32'h1;
                    m_hit = 1;
                end
            end

            if (stun) begin
                m_ph = 0; m_buf = 0; m_hit = 0;
            end else begin
                case (m_ph)
                    0: if (press || m_buf) begin
                        m_word = press ? nw : m_buf_word;
                        m_buf = 0; m_hit = 0; m_ph = 1; m_left = ST;
                    end
                    1: begin m_left--; if (m_left == 0) begin m_ph = 2; m_left = AC; end end
                    2: begin m_left--; if (m_left == 0) begin m_ph = 3; m_left = RC; end end
                    default: begin
                        if (press) begin m_buf = 1; m_buf_word = nw; end
                        m_left--;
                        if (m_left == 0) m_ph = 0;
                    end
                endcase
            end
            m_ap = a_btn;
            m_bp = b_btn;
        end
    end

    initial forever begin
        @(negedge clock);
        if (cmp_en) begin
            chk("cyc_attack", attack, e_att);
            chk("cyc_busy", {31'd0, busy}, {31'd0, e_busy});
            chk("cyc_phase", {30'd0, phase}, {30'd0, e_ph});
        end
    end

    logic [1:0]  ph [0:40];
    logic [31:0] at [0:40];

    task automatic go_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet();
        enable = 1; stun = 0; a_btn = 0; b_btn = 0;
        up = 0; down = 0; left = 0; right = 0; contact = 0;
        repeat (20) go_edge();
    endtask

    // Runs edges P1..Pn after the caller's P0 edge, recording outputs.
    task automatic record(input int n);
        for (int k = 1; k <= n; k++) begin
            go_edge();
            ph[k] = phase;
            at[k] = attack;
        end
    endtask

    int hits, starts;
    logic [1:0] prev_ph;

    initial begin
        reset = 1; enable = 0; stun = 0; a_btn = 0; b_btn = 0;
        up = 0; down = 0; left = 0; right = 0; contact = 0;
        repeat (3) @(posedge clock);
        #7 reset = 0;
        cmp_en = 1;
        chk("reset_attack", attack, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'h0);
        chk("reset_phase", {30'd0, phase}, 32'h0);
        quiet();

        // Plain A move
        a_btn = 1; go_edge();
        record(14);
        chk("a_ph_p1", {30'd0, ph[1]}, 1);
        chk("a_ph_p3", {30'd0, ph[3]}, 1);
        chk("a_ph_p4", {30'd0, ph[4]}, 2);
        chk("a_at_p4", at[4], 32'h20);
        chk("a_at_p7", at[7], 32'h20);
        chk("a_ph_p8", {30'd0, ph[8]}, 3);
        chk("a_at_p8", at[8], 32'h0);
        chk("a_ph_p13", {30'd0, ph[13]}, 3);
        chk("a_ph_p14", {30'd0, ph[14]}, 0);
        chk("a_busy_p14", {31'd0, busy}, 0);
        quiet();

        // Up-B with contact at P5 and P6: single hit pulse
        b_btn = 1; up = 1; go_edge();
        hits = 0;
        for (int k = 1; k <= 14; k++) begin
            go_edge();
            ph[k] = phase; at[k] = attack;
            if (attack[0]) hits++;
            contact = (k == 4 || k == 5);
        end
        chk("ub_at_p4", at[4], 32'h40);
        chk("ub_at_p5", at[5], 32'h41);
        chk("ub_at_p6", at[6], 32'h40);
        chk("ub_at_p7", at[7], 32'h40);
        chk("ub_hits", hits, 1);
        quiet();

        // A and B together, left+right held: side-B left
        a_btn = 1; b_btn = 1; left = 1; right = 1; go_edge();
        record(8);
        chk("both_at_p4", at[4], 32'h100);
        chk("both_at_p7", at[7], 32'h100);
        quiet();

        // Down-B buffered in recovery; press during the next startup dropped
        a_btn = 1; go_edge();
        for (int k = 1; k <= 30; k++) begin
            go_edge();
            ph[k] = phase; at[k] = attack;
            if (k == 2) a_btn = 0;
            if (k == 9) begin b_btn = 1; down = 1; end
            if (k == 15) a_btn = 1;
        end
        chk("buf_ph_p14", {30'd0, ph[14]}, 0);
        chk("buf_ph_p15", {30'd0, ph[15]}, 1);
        chk("buf_ph_p17", {30'd0, ph[17]}, 1);
        chk("buf_at_p18", at[18], 32'h80);
        chk("buf_at_p21", at[21], 32'h80);
        chk("buf_ph_p22", {30'd0, ph[22]}, 3);
        chk("buf_ph_p28", {30'd0, ph[28]}, 0);
        chk("buf_ph_p30", {30'd0, ph[30]}, 0);
        quiet();

        // Stun mid-active
        a_btn = 1; go_edge();
        for (int k = 1; k <= 8; k++) begin
            go_edge();
            ph[k] = phase; at[k] = attack;
            stun = (k == 4);
        end
        chk("stun_at_p4", at[4], 32'h20);
        chk("stun_ph_p6", {30'd0, ph[6]}, 0);
        chk("stun_at_p6", at[6], 32'h0);
        quiet();

        // Stun in recovery discards the buffered move
        a_btn = 1; go_edge();
        for (int k = 1; k <= 20; k++) begin
            go_edge();
            ph[k] = phase; at[k] = attack;
            if (k == 2) a_btn = 0;
            if (k == 9) b_btn = 1;
            stun = (k == 10);
        end
        chk("sbuf_ph_p12", {30'd0, ph[12]}, 0);
        chk("sbuf_ph_p15", {30'd0, ph[15]}, 0);
        chk("sbuf_ph_p17", {30'd0, ph[17]}, 0);
        quiet();

        // Asynchronous reset mid-active
        a_btn = 1; go_edge();
        repeat (5) go_edge();
        chk("rst_pre_at", attack, 32'h20);
        #2 reset = 1;
        #1;
        chk("rst_async_at", attack, 32'h0);
        chk("rst_async_ph", {30'd0, phase}, 0);
        #3 reset = 0;
        quiet();

        // enable low: toggling A does nothing
        enable = 0;
        for (int k = 0; k < 10; k++) begin
            a_btn = ~a_btn;
            go_edge(); go_edge();
            chk("dis_ph", {30'd0, phase}, 0);
            chk("dis_at", attack, 32'h0);
        end
        enable = 1; a_btn = 0; go_edge();

        // Held button starts exactly one move
        a_btn = 1; starts = 0; prev_ph = phase;
        for (int k = 0; k < 40; k++) begin
            go_edge();
            if (phase == 2'd1 && prev_ph != 2'd1) starts++;
            prev_ph = phase;
        end
        chk("held_starts", starts, 1);
        quiet();

        // Randomized play
        for (int k = 0; k < 4000; k++) begin
            go_edge();
            enable  = ($urandom_range(0, 9) != 0);
            stun    = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) a_btn = ~a_btn;
            if ($urandom_range(0, 5) == 0) b_btn = ~b_btn;
            up      = ($urandom_range(0, 3) == 0);
            down    = ($urandom_range(0, 3) == 0);
            left    = ($urandom_range(0, 3) == 0);
            right   = ($urandom_range(0, 3) == 0);
            contact = $urandom_range(0, 1) != 0;
        end
        quiet();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
